sg13g2_io_gpio_ctrl: RTL and testbench

//  Core-side controller for a bank of WIDTH sg13g2_IOPadInOut* pads.

---
 rtl/sg13g2_io_gpio_ctrl.sv | 115 +++++++++++
 tb/tb_sg13g2_io_gpio_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sg13g2_io_gpio_ctrl.sv
// rtl/sg13g2_io_gpio_ctrl.sv - core-side GPIO controller for a bank of sg13g2 bidirectional pads
//
// Output side registers the pad drive (c2p/c2p_en) with per-bit push-pull or
// open-drain behaviour. Input side double-flop synchronises p2c, glitch-filters
// each bit and records filtered edges in sticky rise/fall flags feeding a masked irq.
//
// Ports:
//   clk        in   1      single clock
//   rst_n      in   1      asynchronous active-low reset (released synchronously upstream)
//   out_val    in   WIDTH  value to drive per pad
//   out_en     in   WIDTH  drive enable per pad
//   od_mode    in   WIDTH  1 = open-drain (drive low only), 0 = push-pull
//   c2p        out  WIDTH  registered pad data
//   c2p_en     out  WIDTH  registered pad output enable
//   p2c        in   WIDTH  pad input, asynchronous to clk
//   in_val     out  WIDTH  filtered input level
//   rise_flag  out  WIDTH  sticky 0->1 of in_val
//   fall_flag  out  WIDTH  sticky 1->0 of in_val
//   flag_clr   in   WIDTH  per-bit pulse clearing both flags of that bit
//   irq_mask   in   WIDTH  1 = bit may raise irq
//   irq        out  1      OR of masked flags, combinational from flops
module sg13g2_io_gpio_ctrl #(
    parameter int  WIDTH       = 8,
    parameter int  FILT_CYCLES = 4,
    localparam int CNT_W       = $clog2(FILT_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] out_val,
    input  logic [WIDTH-1:0] out_en,
    input  logic [WIDTH-1:0] od_mode,
    output logic [WIDTH-1:0] c2p,
    output logic [WIDTH-1:0] c2p_en,
    input  logic [WIDTH-1:0] p2c,
    output logic [WIDTH-1:0] in_val,
    output logic [WIDTH-1:0] rise_flag,
    output logic [WIDTH-1:0] fall_flag,
    input  logic [WIDTH-1:0] flag_clr,
    input  logic [WIDTH-1:0] irq_mask,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CYCLES - 1);

    logic [WIDTH-1:0] r_c2p;
    logic [WIDTH-1:0] r_c2p_en;
    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_in_val;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic [CNT_W-1:0] r_cnt [WIDTH];

    logic [WIDTH-1:0] w_accept;
    logic [WIDTH-1:0] w_rise_set;
    logic [WIDTH-1:0] w_fall_set;

    // A bit is accepted on the edge where its synced value has disagreed with
    // in_val for FILT_CYCLES consecutive samples (this edge included).
    always_comb begin
        w_accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_accept[i] = (r_s2[i] != r_in_val[i]) && (r_cnt[i] == CNT_MAX);
        end
    end

    assign w_rise_set = w_accept & r_s2;
    assign w_fall_set = w_accept & ~r_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c2p    <= '0;
            r_c2p_en <= '0;
            r_s1     <= '0;
            r_s2     <= '0;
            r_in_val <= '0;
            r_rise   <= '0;
            r_fall   <= '0;
        end else begin
            // Open-drain bits never drive high: a 1 releases the pad instead.
            r_c2p    <= out_val & ~od_mode;
            r_c2p_en <= out_en & ~(od_mode & out_val);
            r_s1     <= p2c;
            r_s2     <= r_s1;
            r_in_val <= r_in_val ^ w_accept;
            // Set wins over a same-edge clear so no edge is ever lost.
            r_rise   <= w_rise_set | (r_rise & ~flag_clr);
            r_fall   <= w_fall_set | (r_fall & ~flag_clr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if ((r_s2[i] == r_in_val[i]) || w_accept[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign c2p       = r_c2p;
    assign c2p_en    = r_c2p_en;
    assign in_val    = r_in_val;
    assign rise_flag = r_rise;
    assign fall_flag = r_fall;
    assign irq       = |((r_rise | r_fall) & irq_mask);

endmodule

// File: tb/tb_sg13g2_io_gpio_ctrl.sv
// tb/tb_sg13g2_io_gpio_ctrl.sv - self-checking bench for sg13g2_io_gpio_ctrl
module tb_sg13g2_io_gpio_ctrl;

    localparam int W    = 8;
    localparam int FILT = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] out_val = '0;
    logic [W-1:0] out_en = '0;
    logic [W-1:0] od_mode = '0;
    logic [W-1:0] c2p;
    logic [W-1:0] c2p_en;
    logic [W-1:0] p2c = '0;
    logic [W-1:0] in_val;
    logic [W-1:0] rise_flag;
    logic [W-1:0] fall_flag;
    logic [W-1:0] flag_clr = '0;
    logic [W-1:0] irq_mask = '0;
    logic         irq;

    int checks = 0;
    int failures = 0;

    sg13g2_io_gpio_ctrl #(.WIDTH(W), .FILT_CYCLES(FILT)) dut (
        .clk(clk), .rst_n(rst_n),
        .out_val(out_val), .out_en(out_en), .od_mode(od_mode),
        .c2p(c2p), .c2p_en(c2p_en), .p2c(p2c),
        .in_val(in_val), .rise_flag(rise_flag), .fall_flag(fall_flag),
        .flag_clr(flag_clr), .irq_mask(irq_mask), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: pad samples pass through a 2-deep delay line, then a
    // window of the last FILT delayed samples; a bit flips when every sample
    // in its window disagrees with the current filtered level.
    logic [W-1:0] m_c2p, m_en, m_d1, m_d2, m_in, m_rise, m_fall;
    logic [W-1:0] m_win [FILT];

    task automatic model_reset();
        m_c2p = '0; m_en = '0; m_d1 = '0; m_d2 = '0;
        m_in = '0; m_rise = '0; m_fall = '0;
        for (int j = 0; j < FILT; j++) m_win[j] = '0;
    endtask

    task automatic model_edge();
        logic [W-1:0] flip, nin;
        for (int b = 0; b < W; b++) begin
            m_c2p[b] = od_mode[b] ? 1'b0 : out_val[b];
            m_en[b]  = od_mode[b] ? (out_en[b] && !out_val[b]) : out_en[b];
        end
        for (int j = FILT - 1; j > 0; j--) m_win[j] = m_win[j-1];
        m_win[0] = m_d2;
        m_d2 = m_d1;
        m_d1 = p2c;
        flip = '1;
        for (int j = 0; j < FILT; j++) flip = flip & (m_win[j] ^ m_in);
        nin    = m_in ^ flip;
        m_rise = (flip & nin) | (m_rise & ~flag_clr);
        m_fall = (flip & ~nin) | (m_fall & ~flag_clr);
        m_in   = nin;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("c2p", 32'(c2p), 32'(m_c2p));
        chk("c2p_en", 32'(c2p_en), 32'(m_en));
        chk("in_val", 32'(in_val), 32'(m_in));
        chk("rise_flag", 32'(rise_flag), 32'(m_rise));
        chk("fall_flag", 32'(fall_flag), 32'(m_fall));
        chk("irq", 32'(irq), 32'(|((m_rise | m_fall) & irq_mask)));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check_all();
    endtask

    // Called at posedge+1; asserts reset mid-cycle and checks it bites at once.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_c2p_en", 32'(c2p_en), 32'h0);
        check_all();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // T1: drive all enables, then reset asynchronously.
        out_en = '1;
        out_val = 8'h3C;
        step();
        chk("t1_en_driven", 32'(c2p_en), 32'hFF);
        do_reset();
        chk("t1_in_val_rst", 32'(in_val), 32'h0);
        chk("t1_c2p_rst", 32'(c2p), 32'h0);

        // T2: mixed push-pull / open-drain.
        out_val = 8'hA5; out_en = 8'hFF; od_mode = 8'h0F;
        step();
        chk("t2_c2p", 32'(c2p), 32'hA0);
        chk("t2_c2p_en", 32'(c2p_en), 32'hFA);

        // T3: filter latency and glitch rejection on bit 0.
        p2c = 8'h01;
        for (int k = 1; k <= FILT + 2; k++) begin
            step();
            chk("t3_in_val0", 32'(in_val[0]), (k == FILT + 2) ? 32'h1 : 32'h0);
        end
        chk("t3_rise0", 32'(rise_flag[0]), 32'h1);
        p2c = 8'h00;
        for (int k = 0; k < FILT - 1; k++) step();
        p2c = 8'h01;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t3_glitch_hold", 32'(in_val[0]), 32'h1);
        end
        chk("t3_no_fall", 32'(fall_flag[0]), 32'h0);

        // T4: flags and irq on bit 3.
        flag_clr = 8'h01;
        step();
        flag_clr = 8'h00;
        irq_mask = 8'h08;
        p2c = 8'h09;
        for (int k = 0; k < FILT + 2; k++) step();
        flag_clr = 8'h08;
        step();
        flag_clr = 8'h00;
        chk("t4_irq_cleared", 32'(irq), 32'h0);
        p2c = 8'h01;
        for (int k = 0; k < FILT + 2; k++) step();
        chk("t4_fall3", 32'(fall_flag[3]), 32'h1);
        chk("t4_irq_set", 32'(irq), 32'h1);
        flag_clr = 8'h08;
        step();
        flag_clr = 8'h00;
        chk("t4_irq_clr_next", 32'(irq), 32'h0);
        p2c = 8'h09;
        for (int k = 0; k < FILT + 1; k++) step();
        flag_clr = 8'h08;
        step();
        flag_clr = 8'h00;
        chk("t4_set_beats_clr", 32'(rise_flag[3]), 32'h1);
        chk("t4_fall_cleared", 32'(fall_flag[3]), 32'h0);

        // T5: reset while bit 1 is mid-filter and flags are set.
        p2c = 8'h0B;
        for (int k = 0; k < 4; k++) step();
        do_reset();
        chk("t5_flags_rst", 32'(rise_flag | fall_flag), 32'h0);
        for (int k = 1; k <= FILT + 2; k++) begin
            step();
            chk("t5_in_val", 32'(in_val), (k == FILT + 2) ? 32'h0B : 32'h00);
        end

        // Randomised traffic against the model.
        for (int n = 0; n < 600; n++) begin
            out_val = W'($urandom);
            out_en  = W'($urandom);
            od_mode = W'($urandom);
            flag_clr = ($urandom_range(0, 5) == 0) ? W'($urandom) : '0;
            if ($urandom_range(0, 15) == 0) irq_mask = W'($urandom);
            if ($urandom_range(0, 2) == 0) p2c[$urandom_range(0, W - 1)] ^= 1'b1;
            if (n == 300) do_reset();
            else step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
